// File: rtl/dht_frame_reader.sv
// Single-wire DHT11/DHT22 frame reader: host start pulse, response check, pulse-width bit decode, hold-off.
// Optional build macro: DHT_CHECKSUM_EN enables the byte-sum checksum test in CHECK (error code 6).
module dht_frame_reader #(
    parameter int CLK_HZ            = 50_000_000,
    parameter int START_LOW_US      = 18000,
    parameter int RELEASE_US        = 30,
    parameter int RESP_TIMEOUT_US   = 100,
    parameter int BIT_TIMEOUT_US    = 100,
    parameter int BIT_ONE_THRESH_US = 50,
    parameter int HOLDOFF_US        = 1_000_000,
    parameter int NUM_BITS          = 40
) (
    input  logic                i_Clock,
    input  logic                i_Rst_n,
    input  logic                i_Start,
    inout  wire                 io_Dht_Data,
    output logic [NUM_BITS-1:0] o_Data,
    output logic                o_Valid,
    output logic                o_Busy,
    output logic                o_Error,
    output logic [2:0]          o_Err_Code,
    output logic [3:0]          o_Dbg_State
);

    localparam int CYC_PER_US = CLK_HZ / 1_000_000;
    localparam int START_CYC  = CYC_PER_US * START_LOW_US;
    localparam int REL_CYC    = CYC_PER_US * RELEASE_US;
    localparam int RESP_CYC   = CYC_PER_US * RESP_TIMEOUT_US;
    localparam int BIT_CYC    = CYC_PER_US * BIT_TIMEOUT_US;
    localparam int ONE_CYC    = CYC_PER_US * BIT_ONE_THRESH_US;
    localparam int HOLD_CYC   = CYC_PER_US * HOLDOFF_US;

    localparam int MAX_A   = (START_CYC > HOLD_CYC) ? START_CYC : HOLD_CYC;
    localparam int MAX_B   = (RESP_CYC > BIT_CYC) ? RESP_CYC : BIT_CYC;
    localparam int MAX_C   = (REL_CYC > ONE_CYC) ? REL_CYC : ONE_CYC;
    localparam int MAX_AB  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int MAX_CYC = (MAX_AB > MAX_C) ? MAX_AB : MAX_C;
    localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam int BW      = $clog2(NUM_BITS + 1);

    // Limits are "last cycle in state": the counter starts at 0 on state entry.
    localparam logic [CW-1:0] START_LIM = CW'(START_CYC - 1);
    localparam logic [CW-1:0] REL_LIM   = CW'(REL_CYC - 1);
    localparam logic [CW-1:0] RESP_LIM  = CW'(RESP_CYC - 1);
    localparam logic [CW-1:0] BIT_LIM   = CW'(BIT_CYC - 1);
    localparam logic [CW-1:0] ONE_LIM   = CW'(ONE_CYC - 1);
    localparam logic [CW-1:0] HOLD_LIM  = CW'(HOLD_CYC - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(NUM_BITS - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_START_LOW, S_RELEASE, S_RESP_WAIT, S_RESP_LOW, S_RESP_HIGH,
        S_BIT_LOW, S_BIT_HIGH, S_CHECK, S_DONE, S_ERR, S_HOLDOFF
    } state_t;

    state_t                state_q, state_d;
    logic [1:0]            sync_q;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [BW-1:0]         bit_cnt_q;
    logic [NUM_BITS-1:0]   shift_q;
    logic [NUM_BITS-1:0]   data_q;
    logic                  valid_q;
    logic                  error_q;
    logic [2:0]            code_q;
    logic [2:0]            err_code_d;
    logic                  shift_en;
    logic                  bit_val;
    logic                  cks_ok;
    logic                  line_s;

    assign line_s = sync_q[1];

`ifdef DHT_CHECKSUM_EN
    logic [7:0] sum;
    always_comb begin
        sum = 8'd0;
        for (int i = 1; i < NUM_BITS / 8; i++) begin
            sum = sum + shift_q[i*8 +: 8];
        end
        cks_ok = (sum == shift_q[7:0]);
    end
`else
    assign cks_ok = 1'b1;
`endif

    // An observed edge always takes priority over a timeout in the same cycle.
    always_comb begin
        state_d    = state_q;
        err_code_d = 3'd0;
        shift_en   = 1'b0;
        bit_val    = (cnt_q >= ONE_LIM);
        case (state_q)
            S_IDLE:      if (i_Start) state_d = S_START_LOW;
            S_START_LOW: if (cnt_q == START_LIM) state_d = S_RELEASE;
            S_RELEASE:   if (cnt_q == REL_LIM) state_d = S_RESP_WAIT;
            S_RESP_WAIT: begin
                if (!line_s) state_d = S_RESP_LOW;
                else if (cnt_q == RESP_LIM) begin state_d = S_ERR; err_code_d = 3'd1; end
            end
            S_RESP_LOW: begin
                if (line_s) state_d = S_RESP_HIGH;
                else if (cnt_q == RESP_LIM) begin state_d = S_ERR; err_code_d = 3'd2; end
            end
            S_RESP_HIGH: begin
                if (!line_s) state_d = S_BIT_LOW;
                else if (cnt_q == RESP_LIM) begin state_d = S_ERR; err_code_d = 3'd3; end
            end
            S_BIT_LOW: begin
                if (line_s) state_d = S_BIT_HIGH;
                else if (cnt_q == BIT_LIM) begin state_d = S_ERR; err_code_d = 3'd4; end
            end
            S_BIT_HIGH: begin
                if (!line_s) begin
                    shift_en = 1'b1;
                    state_d  = (bit_cnt_q == LAST_BIT) ? S_CHECK : S_BIT_LOW;
                end else if (cnt_q == BIT_LIM) begin
                    state_d    = S_ERR;
                    err_code_d = 3'd5;
                end
            end
            S_CHECK: begin
                if (cks_ok) state_d = S_DONE;
                else begin state_d = S_ERR; err_code_d = 3'd6; end
            end
            S_DONE:    state_d = S_HOLDOFF;
            S_ERR:     state_d = S_HOLDOFF;
            S_HOLDOFF: if (cnt_q == HOLD_LIM) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
        cnt_d = ((state_d != state_q) || (state_q == S_IDLE)) ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q   <= S_IDLE;
            sync_q    <= 2'b11;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            error_q   <= 1'b0;
            code_q    <= 3'd0;
        end else begin
            state_q <= state_d;
            sync_q  <= {sync_q[0], io_Dht_Data};
            cnt_q   <= cnt_d;
            valid_q <= (state_q == S_DONE);
            if (state_q == S_IDLE && i_Start) begin
                bit_cnt_q <= '0;
                error_q   <= 1'b0;
                code_q    <= 3'd0;
            end
            if (shift_en) begin
                shift_q   <= {shift_q[NUM_BITS-2:0], bit_val};
                bit_cnt_q <= bit_cnt_q + 1'b1;
            end
            if (state_q == S_DONE) begin
                data_q  <= shift_q;
                error_q <= 1'b0;
                code_q  <= 3'd0;
            end
            if (state_d == S_ERR && state_q != S_ERR) begin
                error_q <= 1'b1;
                code_q  <= err_code_d;
            end
        end
    end

    // Open-drain: only ever pull low; the external pull-up provides the high level.
    assign io_Dht_Data = (state_q == S_START_LOW) ? 1'b0 : 1'bz;
    assign o_Data      = data_q;
    assign o_Valid     = valid_q;
    assign o_Busy      = (state_q != S_IDLE);
    assign o_Error     = error_q;
    assign o_Err_Code  = code_q;
    assign o_Dbg_State = state_q;

endmodule

// File: tb/tb_dht_frame_reader.sv
// Bench for dht_frame_reader: a behavioural DHT sensor drives the line, expected frames are
// derived from the transmitted data and checksum rule; shortened start pulse keeps runtime small.
module tb_dht_frame_reader;

    localparam int NB        = 40;
    localparam int START_CYC = 1800;
    localparam int HOLD_CYC  = 2000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          sens_low = 1'b0;
    wire           dht_line;
    logic [NB-1:0] data;
    logic          valid, busy, err;
    logic [2:0]    code;
    logic [3:0]    dbg_state;

    int            n_vec = 0;
    int            n_miss = 0;
    int            n_valid = 0;
    logic [NB-1:0] exp_q[$];
    logic [NB-1:0] last_good = '0;

    assign dht_line = sens_low ? 1'b0 : 1'bz;
    pullup (dht_line);

    always #5 clk = ~clk;

    dht_frame_reader #(
        .CLK_HZ       (1_000_000),
        .START_LOW_US (START_CYC),
        .HOLDOFF_US   (HOLD_CYC),
        .NUM_BITS     (NB)
    ) dut (
        .i_Clock     (clk),
        .i_Rst_n     (rst_n),
        .i_Start     (start),
        .io_Dht_Data (dht_line),
        .o_Data      (data),
        .o_Valid     (valid),
        .o_Busy      (busy),
        .o_Error     (err),
        .o_Err_Code  (code),
        .o_Dbg_State (dbg_state)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] cksum(input logic [31:0] d);
        return d[31:24] + d[23:16] + d[15:8] + d[7:0];
    endfunction

    // Scoreboard: every o_Valid pulse must match the oldest expected good frame.
    always @(negedge clk) begin
        if (rst_n && valid) begin
            n_valid++;
            if (exp_q.size() == 0) check_eq("unexpected_valid", valid, 0);
            else                   check_eq("valid_data", data, exp_q.pop_front());
        end
    end

    initial begin
        #(10 * 150_000);
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1);
    end

    task automatic wait_line(input logic lvl, input int max_c, output int c);
        c = 0;
        while (dht_line !== lvl && c < max_c) begin
            @(negedge clk);
            c++;
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Issue a request and measure the host start pulse; returns at the first released cycle.
    task automatic host_start(input string nm);
        int c;
        pulse_start();
        wait_line(1'b0, 10, c);
        check_eq({nm, "_start_low_seen"}, dht_line, 0);
        wait_line(1'b1, START_CYC + 100, c);
        check_eq({nm, "_start_low_len"}, c, START_CYC);
    endtask

    // Sensor reply: response low/high, then NB bits MSB first, then a closing low.
    task automatic sensor_frame(input logic [NB-1:0] frame, input int hold_bit, input int abort_bit);
        int c;
        repeat ($urandom_range(10, 25)) @(negedge clk);
        sens_low = 1'b1;
        repeat ($urandom_range(70, 85)) @(negedge clk);
        sens_low = 1'b0;
        repeat ($urandom_range(70, 85)) @(negedge clk);
        for (int i = 0; i < NB; i++) begin
            sens_low = 1'b1;
            repeat ($urandom_range(30, 45)) @(negedge clk);
            sens_low = 1'b0;
            if (i == abort_bit) begin
                repeat (10) @(negedge clk);
                rst_n = 1'b0;
                #1;
                check_eq("rst_line_z", dht_line, 1);
                check_eq("rst_busy", busy, 0);
                check_eq("rst_data", data, 0);
                check_eq("rst_error", err, 0);
                check_eq("rst_code", code, 0);
                check_eq("rst_valid", valid, 0);
                last_good = '0;
                repeat (3) @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            if (i == hold_bit) begin
                c = 0;
                while (!err && c < 300) begin
                    @(negedge clk);
                    c++;
                end
                check_eq($sformatf("bit_high_tmo_latency(%0d)", c), (c >= 100 && c <= 106), 1);
                c = 0;
                while (busy && c < 3000) begin
                    @(negedge clk);
                    c++;
                end
                check_eq($sformatf("holdoff_busy_len(%0d)", c),
                         (c >= HOLD_CYC - 1 && c <= HOLD_CYC + 2), 1);
                return;
            end
            repeat (frame[NB-1-i] ? $urandom_range(65, 75) : $urandom_range(15, 25)) @(negedge clk);
        end
        sens_low = 1'b1;
        repeat (40) @(negedge clk);
        sens_low = 1'b0;
    endtask

    task automatic finish_frame(input string nm, input logic e, input logic [2:0] cd,
                                input int nv_exp, input int nv0);
        int b = 0;
        while (busy && b < 8000) begin
            @(negedge clk);
            b++;
        end
        check_eq({nm, "_idle"}, busy, 0);
        check_eq({nm, "_error"}, err, e);
        check_eq({nm, "_code"}, code, cd);
        check_eq({nm, "_data"}, data, last_good);
        check_eq({nm, "_valid_count"}, n_valid - nv0, nv_exp);
        check_eq({nm, "_exp_pending"}, exp_q.size(), 0);
    endtask

    task automatic good_frame(input string nm, input logic [NB-1:0] f);
        int nv0 = n_valid;
        exp_q.push_back(f);
        host_start(nm);
        sensor_frame(f, -1, -1);
        last_good = f;
        finish_frame(nm, 1'b0, 3'd0, 1, nv0);
    endtask

    function automatic logic [NB-1:0] rand_frame();
        logic [31:0] d = $urandom;
        return {d, cksum(d)};
    endfunction

    initial begin
        int            c;
        int            nv0;
        int            seen;
        logic [NB-1:0] f;

        repeat (3) @(negedge clk);
        check_eq("reset_line", dht_line, 1);
        check_eq("reset_data", data, 0);
        check_eq("reset_valid", valid, 0);
        check_eq("reset_busy", busy, 0);
        check_eq("reset_error", err, 0);
        check_eq("reset_code", code, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        good_frame("good", 40'h3700190050);

        nv0 = n_valid;
        host_start("silent");
        c = 0;
        while (!err && c < 500) begin
            @(negedge clk);
            c++;
        end
        check_eq($sformatf("silent_err_latency(%0d)", c), (c >= 126 && c <= 136), 1);
        finish_frame("silent", 1'b1, 3'd1, 0, nv0);

        f = 40'h3700190051;
        nv0 = n_valid;
`ifndef DHT_CHECKSUM_EN
        exp_q.push_back(f);
`endif
        host_start("cksum");
        sensor_frame(f, -1, -1);
`ifdef DHT_CHECKSUM_EN
        finish_frame("cksum", 1'b1, 3'd6, 0, nv0);
`else
        last_good = f;
        finish_frame("cksum", 1'b0, 3'd0, 1, nv0);
`endif

        nv0 = n_valid;
        host_start("hold12");
        sensor_frame(rand_frame(), 12, -1);
        finish_frame("hold12", 1'b1, 3'd5, 0, nv0);

        for (int k = 0; k < 2; k++) begin
            f = rand_frame();
            nv0 = n_valid;
            exp_q.push_back(f);
            host_start("ignore");
            fork
                sensor_frame(f, -1, -1);
                repeat (3) begin
                    repeat ($urandom_range(100, 500)) @(negedge clk);
                    start = 1'b1;
                    @(negedge clk);
                    start = 1'b0;
                end
            join
            last_good = f;
            repeat (3) begin
                repeat ($urandom_range(100, 400)) @(negedge clk);
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
            finish_frame($sformatf("ignore%0d", k), 1'b0, 3'd0, 1, nv0);
            seen = 0;
            repeat (30) begin
                @(negedge clk);
                if (busy || dht_line !== 1'b1) seen = 1;
            end
            check_eq($sformatf("ignore%0d_no_queued_start", k), seen, 0);
        end

        host_start("reset20");
        sensor_frame(rand_frame(), -1, 20);
        repeat (5) @(negedge clk);
        check_eq("post_rst_busy", busy, 0);

        good_frame("after_rst", rand_frame());

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
